cpu_decode_queue: RTL and testbench

CPU_DECODE_QUEUE -- requirements
Module: cpu_decode_queue

---
 rtl/cpu_decode_queue.sv | 125 ++++++++++++
 tb/tb_cpu_decode_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_decode_queue.sv
// Instruction queue between fetch and decode. Each instruction is decoded as it
// is written, and the decoded fields are stored next to the raw word.
module cpu_decode_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_instr,
  input  logic [ADDR_WIDTH-1:0]        in_next_pc,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_instr,
  output logic [ADDR_WIDTH-1:0]        out_next_pc,
  output logic [6:0]                   out_opcode,
  output logic [1:0]                   out_fmt,
  output logic [4:0]                   out_dst,
  output logic [4:0]                   out_src1,
  output logic [4:0]                   out_src2,
  output logic [ADDR_WIDTH-1:0]        out_imm,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  localparam logic [1:0] FMT_R = 2'd0, FMT_M = 2'd1, FMT_B = 2'd2, FMT_X = 2'd3;

  typedef struct packed {
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [1:0]            fmt;
    logic [4:0]            dst;
    logic [4:0]            src1;
    logic [4:0]            src2;
    logic [ADDR_WIDTH-1:0] imm;
    logic                  illegal;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec, head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop;

  // Widening sign extension; for narrow ADDR_WIDTH this truncates to the low bits.
  function automatic logic [ADDR_WIDTH-1:0] sext15(input logic [14:0] v);
    logic [ADDR_WIDTH+14:0] w;
    w = {{ADDR_WIDTH{v[14]}}, v};
    return w[ADDR_WIDTH-1:0];
  endfunction

  always_comb begin
    dec         = '0;
    dec.instr   = in_instr;
    dec.next_pc = in_next_pc;
    case (in_instr[6:0])
      7'h00, 7'h01, 7'h02, 7'h32, 7'h33: begin
        dec.fmt  = FMT_R;
        dec.dst  = in_instr[11:7];
        dec.src1 = in_instr[16:12];
        dec.src2 = in_instr[21:17];
      end
      7'h10, 7'h11, 7'h12, 7'h13, 7'h14: begin
        dec.fmt  = FMT_M;
        dec.dst  = in_instr[11:7];
        dec.src1 = in_instr[16:12];
        dec.imm  = sext15(in_instr[31:17]);
      end
      7'h30, 7'h31: begin
        dec.fmt  = FMT_B;
        dec.src1 = in_instr[16:12];
        dec.src2 = in_instr[21:17];
        dec.imm  = sext15({in_instr[11:7], in_instr[31:22]});
      end
      default: begin
        dec.fmt     = FMT_X;
        dec.illegal = 1'b1;
      end
    endcase
  end

  assign in_ready  = (count < C_FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;
      if (push && !pop)      count <= count + C_ONE;
      else if (pop && !push) count <= count - C_ONE;
    end
  end

  // Data outputs read as zero whenever the queue is empty, including in reset.
  assign head        = out_valid ? mem[rd_ptr] : '0;
  assign out_instr   = head.instr;
  assign out_next_pc = head.next_pc;
  assign out_opcode  = head.instr[6:0];
  assign out_fmt     = head.fmt;
  assign out_dst     = head.dst;
  assign out_src1    = head.src1;
  assign out_src2    = head.src2;
  assign out_imm     = head.imm;
  assign out_illegal = head.illegal;
endmodule

// File: tb/tb_cpu_decode_queue.sv
// Directed bench for cpu_decode_queue: decode classes, fill/wrap ordering,
// flush priority and asynchronous reset.
module tb_cpu_decode_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_next_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr, out_next_pc, out_imm;
  logic [6:0]  out_opcode;
  logic [1:0]  out_fmt;
  logic [4:0]  out_dst, out_src1, out_src2;
  logic        out_illegal;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  cpu_decode_queue #(.ADDR_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_next_pc(in_next_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_next_pc(out_next_pc),
    .out_opcode(out_opcode), .out_fmt(out_fmt), .out_dst(out_dst), .out_src1(out_src1),
    .out_src2(out_src2), .out_imm(out_imm), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge; inputs were set beforehand, outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = ins; in_next_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop1();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [31:0] exp_pc[$];
  logic [31:0] exp_in[$];
  int mc, offered, accepted, popped;
  logic [31:0] ins;

  initial begin
    // Reset state
    #12;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // R-type
    push1(32'h0002_3082, 32'h104);
    chk("r_valid", out_valid, 1);
    chk("r_fmt", out_fmt, 0);
    chk("r_opcode", out_opcode, 7'h02);
    chk("r_dst", out_dst, 1);
    chk("r_src1", out_src1, 3);
    chk("r_src2", out_src2, 1);
    chk("r_imm", out_imm, 0);
    chk("r_pc", out_next_pc, 32'h104);
    chk("r_count", count, 1);
    pop1();
    chk("r_empty", out_valid, 0);
    chk("r_empty_instr", out_instr, 0);

    // M-type, negative immediate; instr[21:17] nonzero but src2 must be 0
    push1(32'hFFFE_4111, 32'h108);
    chk("m_fmt", out_fmt, 1);
    chk("m_imm", out_imm, 32'hFFFF_FFFF);
    chk("m_dst", out_dst, 2);
    chk("m_src1", out_src1, 4);
    chk("m_src2", out_src2, 0);
    pop1();

    // B-type
    push1(32'h000C_5830, 32'h10C);
    chk("b_fmt", out_fmt, 2);
    chk("b_imm", out_imm, 32'hFFFF_C000);
    chk("b_dst", out_dst, 0);
    chk("b_src1", out_src1, 5);
    chk("b_src2", out_src2, 6);
    pop1();
    chk("b_count", count, 0);

    // Fill to full, then a dropped push
    for (int i = 0; i < 4; i++) begin
      push1({20'h0, 5'(i), 7'h00}, 32'h2000 + 32'(4*i));
      exp_pc.push_back(32'h2000 + 32'(4*i));
      exp_in.push_back({20'h0, 5'(i), 7'h00});
    end
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    push1(32'h0000_0F80, 32'hDEAD);
    chk("full_drop_count", count, 4);

    // Stream with out_ready held high until 6 more entries are accepted
    mc = 4; offered = 0; accepted = 0; popped = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && (exp_pc.size() != 0 || accepted < 6); cyc++) begin
      in_valid = (accepted < 6);
      ins = {20'h0, 5'(offered + 4), 7'h01};
      in_instr = ins;
      in_next_pc = 32'h3000 + 32'(4*offered);
      if (mc > 0) begin
        chk("wrap_pc", out_next_pc, exp_pc[0]);
        chk("wrap_instr", out_instr, exp_in[0]);
      end
      tick();
      if (mc > 0) begin
        void'(exp_pc.pop_front()); void'(exp_in.pop_front());
        popped++;
      end
      if (in_valid) begin
        if (mc < 4 || (mc == 4 && 0)) begin end
      end
      // Acceptance judged on occupancy before the edge
      if (in_valid && (mc < 4)) begin
        exp_pc.push_back(32'h3000 + 32'(4*offered));
        exp_in.push_back(ins);
        accepted++;
        if (!(popped > 0 && mc > 0)) mc++;
      end
      if (in_valid) offered++;
      mc = exp_pc.size();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("wrap_popped", popped, 10);
    chk("wrap_drained", count, 0);

    // Flush beats a same-cycle push and pop
    for (int i = 0; i < 3; i++) push1(32'h0000_0000, 32'h4000 + 32'(4*i));
    chk("fl_pre_count", count, 3);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0000_ABB2; in_next_pc = 32'hF1F1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_instr", out_instr, 0);
    chk("fl_pc", out_next_pc, 0);
    tick();
    chk("fl_stays_empty", out_valid, 0);
    push1(32'h0002_3082, 32'h5000);
    chk("fl_next_pc", out_next_pc, 32'h5000);
    pop1();

    // Illegal opcode, then async reset with two entries queued
    push1(32'hFFFF_FFFF, 32'h6000);
    chk("il_illegal", out_illegal, 1);
    chk("il_fmt", out_fmt, 3);
    chk("il_dst", out_dst, 0);
    chk("il_src1", out_src1, 0);
    chk("il_src2", out_src2, 0);
    chk("il_imm", out_imm, 0);
    chk("il_instr", out_instr, 32'hFFFF_FFFF);
    push1(32'h0000_0000, 32'h6004);
    chk("ar_pre_count", count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_count", count, 0);
    chk("ar_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    push1(32'h0000_0011, 32'h7000);
    chk("ar_after_count", count, 1);
    chk("ar_after_pc", out_next_pc, 32'h7000);
    chk("ar_after_fmt", out_fmt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
